// File: rtl/alu_obf_sched.sv
// alu_obf_sched: round-robin arbiter in front of a key-locked add/sub/multiply core.
// One operation in flight at a time; the result is held on a back-pressured response channel.
module alu_obf_sched #(
  parameter int DP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [7:0]   req0_in1,
  input  logic [7:0]   req0_in2,
  input  logic [7:0]   req0_in3,
  input  logic         req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [7:0]   req1_in1,
  input  logic [7:0]   req1_in2,
  input  logic [7:0]   req1_in3,
  input  logic         req1_sel,
  input  logic [254:0] locking_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [7:0]   rsp_out1,
  output logic [7:0]   rsp_out2,
  output logic         busy,
  output logic [15:0]  done_cnt0,
  output logic [15:0]  done_cnt1
);

  // state | meaning
  // IDLE  | no operation in flight, arbitration open
  // BUSY  | datapath settle counter running
  // DONE  | response held until the consumer takes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DP_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        grant_id;
  logic        cur_id;
  logic        hs;
  logic        rsp_fire;
  logic [7:0]  lat_in1, lat_in2, lat_in3;
  logic        lat_sel;
  logic [9:0]  lat_key;
  logic [7:0]  key_mask;
  logic [7:0]  dp_out1, dp_out2;
  logic        unused_key;

  assign unused_key = ^locking_key[254:10];

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign hs       = (state == IDLE) && !rst && (req0_valid || req1_valid);
  assign rsp_fire = (state == DONE) && rsp_ready;

  // Locked core operates only on the captured operands and key.
  assign key_mask = 8'h67 ^ lat_key[9:2];
  assign dp_out1  = (lat_sel ^ lat_key[1]) ? (lat_in1 - lat_in2) : (lat_in1 + lat_in2);
  assign dp_out2  = lat_in3 * key_mask;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    rsp_valid  = (state == DONE);
    req0_ready = hs && !grant_id;
    req1_ready = hs && grant_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      lat_in1    <= 8'd0;
      lat_in2    <= 8'd0;
      lat_in3    <= 8'd0;
      lat_sel    <= 1'b0;
      lat_key    <= 10'd0;
      rsp_id     <= 1'b0;
      rsp_out1   <= 8'd0;
      rsp_out2   <= 8'd0;
      done_cnt0  <= 16'd0;
      done_cnt1  <= 16'd0;
    end else begin
      if (hs) begin
        lat_in1    <= grant_id ? req1_in1 : req0_in1;
        lat_in2    <= grant_id ? req1_in2 : req0_in2;
        lat_in3    <= grant_id ? req1_in3 : req0_in3;
        lat_sel    <= grant_id ? req1_sel : req0_sel;
        lat_key    <= locking_key[9:0];
        cur_id     <= grant_id;
        last_grant <= grant_id;
        cnt        <= CNT_INIT;
      end
      if (state == BUSY) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_out1 <= dp_out1;
          rsp_out2 <= dp_out2;
          rsp_id   <= cur_id;
        end
      end
      if (rsp_fire) begin
        if (rsp_id) done_cnt1 <= done_cnt1 + 16'd1;
        else        done_cnt0 <= done_cnt0 + 16'd1;
      end
    end
  end

endmodule
